// File: rtl/window_shift_buffer.sv
// Multi-channel circular frame store with a sliding read window walking from the newest frame back.
// Read latency 1 cycle; no backpressure: writes to a full store drop (overflow), pops/reads on empty are ignored (underflow).
module window_shift_buffer #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 1,
  parameter int WINDOW     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           wren,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   i_data,
  input  logic                           pop,
  input  logic                           rden,
  input  logic                           rewind,
  output logic [NUM_CH*DATA_WIDTH-1:0]   o_data,
  output logic                           o_valid,
  output logic                           o_last,
  output logic                           readytoread,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int FW = NUM_CH * DATA_WIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = PW + 1;

  logic [FW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] tap;

  logic          wr_acc;
  logic          pop_acc;
  logic          rd_acc;
  logic          wrap;
  logic [CW-1:0] sweep_len;
  logic [CW-1:0] last_tap;
  logic [CW-1:0] cur_tap;
  logic [CW-1:0] rd_tap;
  logic [AW-1:0] addr_sum;
  logic [PW-1:0] rd_addr;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign readytoread = (count >= CW'(WINDOW));

  always_comb begin
    wr_acc    = wren && (!full || pop);
    pop_acc   = pop && !empty;
    rd_acc    = rden && !empty;
    sweep_len = (count < CW'(WINDOW)) ? count : CW'(WINDOW);
    last_tap  = sweep_len - CW'(1);
    cur_tap   = rewind ? '0 : tap;
    // A pop may have shrunk the sweep below the current tap: clamp to the last tap and wrap.
    wrap      = (cur_tap >= last_tap);
    rd_tap    = wrap ? last_tap : cur_tap;
    addr_sum  = AW'(wr_ptr) + AW'(DEPTH - 1) - AW'(rd_tap);
    rd_addr   = (addr_sum >= AW'(DEPTH)) ? PW'(addr_sum - AW'(DEPTH)) : PW'(addr_sum);
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      wr_ptr    <= '0;
      tap       <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      count     <= '0;
      wr_ptr    <= '0;
      tap       <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      case ({wr_acc, pop_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      o_valid <= rd_acc;
      o_last  <= rd_acc && wrap;
      if (rd_acc) begin
        o_data <= mem[rd_addr];
        tap    <= wrap ? '0 : cur_tap + CW'(1);
      end else if (rewind) begin
        tap <= '0;
      end
      if (wren && full && !pop) overflow <= 1'b1;
      if ((pop || rden) && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_window_shift_buffer.sv
// Scoreboard bench: queue-based reference model predicts reads; monitor compares each o_valid beat.
module tb_window_shift_buffer;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int NCH   = 2;
  localparam int WIN   = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int FW    = NCH * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0, wren = 1'b0, pop = 1'b0, rden = 1'b0, rewind = 1'b0;
  logic [FW-1:0] i_data = '0;
  logic [FW-1:0] o_data;
  logic          o_valid, o_last, readytoread, full, empty, overflow, underflow;
  logic [CW-1:0] count;

  window_shift_buffer #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_CH(NCH), .WINDOW(WIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .i_data(i_data),
    .pop(pop), .rden(rden), .rewind(rewind), .o_data(o_data),
    .o_valid(o_valid), .o_last(o_last), .readytoread(readytoread),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0] dat;
    logic          last;
  } exp_t;

  int            total = 0;
  int            bad   = 0;
  logic [FW-1:0] m_q[$];   // model frames, oldest at front
  int            m_tap = 0;
  bit            m_ovf = 0;
  bit            m_udf = 0;
  exp_t          sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int n;
    n = m_q.size();
    chk("count", 64'(count), 64'(n));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("readytoread", 64'(readytoread), 64'(n >= WIN));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_udf));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_tap = 0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  task automatic model_step(input bit w, input logic [FW-1:0] d, input bit p, input bit r,
                            input bit rw, input bit c);
    int   n, l, t, rt;
    exp_t e;
    n = m_q.size();
    if (c) begin
      model_reset();
      return;
    end
    if (r) begin
      if (n == 0) m_udf = 1;
      else begin
        l      = (n < WIN) ? n : WIN;
        t      = rw ? 0 : m_tap;
        rt     = (t >= l - 1) ? l - 1 : t;
        e.dat  = m_q[n - 1 - rt];
        e.last = (t >= l - 1);
        sb_q.push_back(e);
        m_tap  = e.last ? 0 : t + 1;
      end
    end else if (rw) begin
      m_tap = 0;
    end
    if (p && n == 0) m_udf = 1;
    if (w && n == DEPTH && !p) m_ovf = 1;
    if (p && n > 0) void'(m_q.pop_front());
    if (w && (n < DEPTH || p)) m_q.push_back(d);
  endtask

  task automatic cycle(input bit w, input logic [FW-1:0] d, input bit p, input bit r,
                       input bit rw, input bit c);
    @(negedge clk);
    check_status();
    wren = w; i_data = d; pop = p; rden = r; rewind = rw; clr = c;
    model_step(w, d, p, r, rw, c);
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [FW-1:0] d);
    cycle(1, d, 0, 0, 0, 0);
  endtask

  task automatic rd(input bit rw);
    cycle(0, '0, 0, 1, rw, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_rtr"}, 64'(readytoread), 64'd0);
    chk({tag, "_odata"}, 64'(o_data), 64'd0);
    chk({tag, "_ovalid"}, 64'(o_valid), 64'd0);
    chk({tag, "_olast"}, 64'(o_last), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_udf"}, 64'(underflow), 64'd0);
  endtask

  // Asserted away from the clock edge so the check sees the asynchronous clear.
  task automatic async_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    wren = 0; pop = 0; rden = 0; rewind = 0; clr = 0; i_data = '0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every o_valid beat must match the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: actual o_data=%0h expected no beat at %0t", o_data, $time);
        end else begin
          e = sb_q.pop_front();
          chk("rd_data", 64'(o_data), 64'(e.dat));
          chk("rd_last", 64'(o_last), 64'(e.last));
        end
      end
    end
  end

  initial begin
    bit w, p, r, rw, c;
    async_reset("rst0");

    // three frames, two full sweeps
    wr(32'h11); wr(32'h22); wr(32'h33);
    idle();
    chk("three_count", 64'(count), 64'd3);
    for (int i = 0; i < 6; i++) rd(0);
    idle();

    // fill, overflow, then write-with-pop at full
    cycle(0, '0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) wr(FW'(i));
    cycle(1, 32'd9, 0, 0, 0, 0);
    idle();
    chk("ovf_count", 64'(count), 64'd8);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    cycle(1, 32'd9, 1, 0, 0, 0);
    rd(1); rd(0);
    for (int i = 0; i < 7; i++) cycle(0, '0, 1, 0, 0, 0);
    rd(1);
    idle();

    // rewind mid-sweep
    cycle(0, '0, 0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) wr(FW'(i));
    rd(0); rd(0); rd(1); rd(0);
    // pop below the current tap so the next read clamps
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, 0, 0);
    rd(0); rd(0);
    idle();

    // single frame, then empty-side underflow
    cycle(0, '0, 0, 0, 0, 1);
    wr(32'hAB);
    rd(0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    rd(0);
    idle();
    chk("udf_flag", 64'(underflow), 64'd1);
    chk("udf_count", 64'(count), 64'd0);

    // channel packing
    wr({16'hBEEF, 16'h1234});
    rd(0);
    idle();

    // reset while a beat is on the output
    wr(32'h55); wr(32'h66);
    rd(0);
    @(negedge clk);
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    rst_n = 1'b0;
    wren = 0; pop = 0; rden = 0; rewind = 0; clr = 0; i_data = '0;
    #1;
    check_reset_values("rst_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(); idle();

    // clear wins over a simultaneous write
    wr(32'h77); wr(32'h88);
    cycle(1, 32'h99, 0, 1, 0, 1);
    idle();
    chk("clr_count", 64'(count), 64'd0);
    rd(0);
    idle();
    chk("clr_udf", 64'(underflow), 64'd1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      w  = ($urandom_range(0, 99) < 50);
      p  = ($urandom_range(0, 99) < 25);
      r  = ($urandom_range(0, 99) < 50);
      rw = ($urandom_range(0, 99) < 10);
      c  = ($urandom_range(0, 999) < 15);
      cycle(w, FW'($urandom()), p, r, rw, c);
    end
    idle(); idle(); idle();
    chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
